// File: rtl/gpio_in_conditioner.sv
// Conditions raw GPIO pad inputs: 2-FF synchronizer, per-bit counter debounce,
// and single-cycle rise/fall strobes for the core logic.
module gpio_in_conditioner #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] gpio_raw_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             any_edge_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            level_q, level_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            // Disabled or agreeing bits restart their count so a full window is always required.
            if (!en_i || (sync2_q[i] == level_q[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = sync2_q[i];
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= gpio_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign any_edge_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with WIDTH=8, DEBOUNCE_CYCLES=4.
module tb_gpio_in_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] gpio_raw;
    logic [7:0] level, rise, fall;
    logic       any_edge;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] seen_rise;
    logic [7:0] seen_level_chg;

    gpio_in_conditioner #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .gpio_raw_i(gpio_raw),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .any_edge_o(any_edge)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        gpio_raw = 8'hFF;
        ticks(2);

        // 1: reset state, then all bits debounce high after release
        check_eq("rst_level", level, 8'h00);
        check_eq("rst_rise", rise, 8'h00);
        check_eq("rst_fall", fall, 8'h00);
        check_eq("rst_any", any_edge, 1'b0);
        rst = 1'b0;
        ticks(5);
        check_eq("t1_level_e5", level, 8'h00);
        tick();
        check_eq("t1_level_e6", level, 8'hFF);
        check_eq("t1_rise_e6", rise, 8'hFF);
        check_eq("t1_any_e6", any_edge, 1'b1);
        tick();
        check_eq("t1_rise_e7", rise, 8'h00);
        check_eq("t1_any_e7", any_edge, 1'b0);

        // return all bits low, checking fall strobes
        gpio_raw = 8'h00;
        ticks(6);
        check_eq("fall_level", level, 8'h00);
        check_eq("fall_pulse", fall, 8'hFF);
        check_eq("fall_no_rise", rise, 8'h00);
        tick();
        check_eq("fall_pulse_end", fall, 8'h00);
        ticks(3);

        // 2: single bit rise
        gpio_raw = 8'h01;
        ticks(5);
        check_eq("t2_level_e5", level, 8'h00);
        tick();
        check_eq("t2_level_e6", level, 8'h01);
        check_eq("t2_rise_e6", rise, 8'h01);
        check_eq("t2_fall_e6", fall, 8'h00);
        tick();
        check_eq("t2_rise_e7", rise, 8'h00);

        // 3: 3-cycle glitch on bit3 is rejected
        seen_rise = '0;
        seen_level_chg = '0;
        gpio_raw = 8'h09;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen_rise |= rise;
            seen_level_chg |= level ^ 8'h01;
        end
        gpio_raw = 8'h01;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen_rise |= rise;
            seen_level_chg |= level ^ 8'h01;
        end
        check_eq("t3_no_rise", seen_rise, 8'h00);
        check_eq("t3_level_stable", seen_level_chg, 8'h00);

        // 4: bits 2 and 5 change together
        gpio_raw = 8'h25;
        ticks(5);
        check_eq("t4_level_e5", level, 8'h01);
        check_eq("t4_any_e5", any_edge, 1'b0);
        tick();
        check_eq("t4_level_e6", level, 8'h25);
        check_eq("t4_rise_e6", rise, 8'h24);
        check_eq("t4_any_e6", any_edge, 1'b1);
        tick();
        check_eq("t4_any_e7", any_edge, 1'b0);

        // 5: enable low freezes debounce; bit1 accepted 4 edges after re-enable
        en = 1'b0;
        gpio_raw = 8'h27;
        seen_rise = '0;
        seen_level_chg = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen_rise |= rise;
            seen_level_chg |= level ^ 8'h25;
        end
        check_eq("t5_frozen_rise", seen_rise, 8'h00);
        check_eq("t5_frozen_level", seen_level_chg, 8'h00);
        en = 1'b1;
        ticks(3);
        check_eq("t5_level_e3", level, 8'h25);
        tick();
        check_eq("t5_level_e4", level, 8'h27);
        check_eq("t5_rise_e4", rise, 8'h02);
        tick();
        check_eq("t5_rise_e5", rise, 8'h00);

        // 6: async reset mid-count on bit7, then full latency from level 0
        gpio_raw = 8'hA7;
        ticks(4);
        check_eq("t6_level_midcount", level, 8'h27);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_async_level", level, 8'h00);
        check_eq("t6_async_rise", rise, 8'h00);
        check_eq("t6_async_any", any_edge, 1'b0);
        ticks(2);
        rst = 1'b0;
        ticks(5);
        check_eq("t6_level_e5", level, 8'h00);
        tick();
        check_eq("t6_level_e6", level, 8'hA7);
        check_eq("t6_rise_e6", rise, 8'hA7);
        tick();
        check_eq("t6_rise_e7", rise, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
